icache_nway: RTL and testbench
==============================

// Module: icache_nway
// PURPOSE
//  Parametrised N-way set-associative instruction cache; successor to the fixed direct-mapped icache.
//  Sits between the datapath fetch port and the memory controller's instruction channel.
//  Configurable sets, ways and words per block; fills a block word-by-word on a miss.
//  Uses round-robin victim selection per set.
// PARAMETERS
//  SETS             8  number of sets; power of two, >=2
//  WAYS             2  associativity; power of two, 1..8
//  WORDS_PER_BLOCK  2  32-bit words per line; power of two, 1..8
// PORTS
//  CLK         in   1   clock; all state updates on the rising edge
//  RST         in   1   reset; synchronous, active-high
//  imemREN     in   1   datapath fetch request
//  imemaddr    in   32  datapath fetch byte address; bits [1:0] ignored
//  ihit        out  1   requested word valid this cycle
//  imemload    out  32  fetched instruction; 0 when ihit=0
//  iREN        out  1   memory read request
//  iaddr       out  32  memory word address, word aligned
//  iload       in   32  memory read data
//  iwait       in   1   memory busy; data is accepted when iREN && !iwait
// BEHAVIOUR
//  Address split: [1:0] byte, then log2(WORDS_PER_BLOCK) word offset, then log2(SETS) index; the tag is the rest.
//  Reset: all valid bits 0, FSM=IDLE, victim pointers 0, fill counter 0; ihit=0, imemload=0, iREN=0, iaddr=0.
//  FSM states:
//   IDLE: combinational lookup of all ways in the indexed set.
//     Hit (imemREN && valid && tag match): ihit=1 in the same cycle, imemload=the stored word; state unchanged.
//     Miss with imemREN: latch block base address, index and victim way; go to FILL next cycle.
//     imemREN=0: nothing happens.
//   FILL: iREN=1, iaddr=base+4*cnt, ihit=0.
//     On each iREN && !iwait: write iload into the victim line word[cnt], then cnt++.
//     After the last word: set valid, write the tag, advance the set's victim pointer modulo WAYS; go to IDLE.
//  Miss latency: the hit occurs on the first IDLE cycle after the fill, i.e. the cycle after the last accepted word.
//  Victim choice: the lowest-numbered invalid way if any exist; otherwise the round-robin pointer of that set.
//   The pointer advances only on fills.
//  Boundaries:
//   imemaddr changes or imemREN drops during FILL: the fill always completes for the latched address.
//   iwait held high indefinitely: remain in FILL with iREN/iaddr stable.
//   RST during FILL: fill is abandoned; the partial line stays invalid (valid is set only on completion).
//   A line's data/tag is never returned until valid is set.
//   WAYS=1 degenerates to direct-mapped; victim logic then always selects way 0.
//  No write path; self-modifying code is not supported.
// CONFIGURATION
//  Macro ICACHE_STATS_EN:
//   Defined: adds outputs hit_count[31:0] and miss_count[31:0].
//     hit_count increments on each IDLE-state hit cycle; miss_count increments on each IDLE-to-FILL transition.
//     Both saturate at 0xFFFF_FFFF and reset to 0.
//   Undefined: these ports and counters do not exist; behaviour is otherwise identical.
// STRUCTURE
//  icache_nway_pkg: FSM state enum (IDLE, FILL), and localparam functions for offset, index and tag widths.
//   The package also holds a packed line typedef {valid, tag, word_t data[WORDS_PER_BLOCK]}.
//  word_t comes from the shared cpu types package.
//  One sub-module, cache_victim_sel: per-set round-robin pointers.
//   Inputs: valid vector of the indexed set and an advance strobe. Output: the victim way.
//  Storage: flop arrays indexed [SETS][WAYS]; no SRAM macro.
// TESTING (SETS=8, WAYS=2, WORDS_PER_BLOCK=2; iwait low 2 cycles after each iREN rise)
//  1 Cold miss, imemaddr=0x40:
//    -> iREN fetches 0x40 then 0x44 (data 0xAAAA0001, 0xAAAA0002);
//    -> then ihit=1 with imemload=0xAAAA0001; next, addr 0x44 hits immediately with 0xAAAA0002.
//  2 Fill 0x40, then 0x80 (same index 0, tag 2):
//    -> both go to separate ways; alternating reads of 0x40/0x80 give ihit=1 every cycle with no iREN.
//  3 Fill 0x40, 0x80, then 0xC0:
//    -> 0xC0 evicts way 0 (0x40); 0x80 still hits; 0x40 now misses and evicts way 1 (0x80).
//  4 During the fill of 0x40, switch imemaddr to 0x100 and drop imemREN:
//    -> both words of 0x40 are still fetched; then 0x100 misses and 0x40 hits.
//  5 RST asserted after the first word of the 0x40 fill:
//    -> all outputs 0 next cycle; a subsequent read of 0x40 misses and refetches both words.
//  6 With ICACHE_STATS_EN, run scenario 2 plus 4 more hits:
//    -> miss_count=2, hit_count=(hit cycles including the fill-completion hits) as counted by the scoreboard.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
package cpu_types_pkg;
   typedef logic [31:0] word_t;
endpackage

// File: rtl/icache_nway_pkg.sv
// Types and geometry helpers for the N-way instruction cache.
package icache_nway_pkg;
   import cpu_types_pkg::*;

   typedef enum logic {IDLE, FILL} state_t;

   function automatic int off_w(int wpb);
      return $clog2(wpb);
   endfunction

   function automatic int idx_w(int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_w(int sets, int wpb);
      return 30 - $clog2(sets) - $clog2(wpb);
   endfunction

   // Way pointers keep at least one bit so WAYS=1 still has a legal vector.
   function automatic int way_w(int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

   localparam int DEF_SETS = 8;
   localparam int DEF_WPB  = 2;

   typedef struct packed {
      logic                               valid;
      logic [tag_w(DEF_SETS, DEF_WPB)-1:0] tag;
      word_t [DEF_WPB-1:0]                data;
   } line_t;
endpackage

// File: rtl/cache_victim_sel.sv
// Per-set round-robin victim pointers; an invalid way always wins over the pointer.
module cache_victim_sel import icache_nway_pkg::*; #(
   parameter int SETS = 8,
   parameter int WAYS = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [idx_w(SETS)-1:0]   idx,
   input  logic [WAYS-1:0]          valid,
   input  logic                     adv,
   output logic [way_w(WAYS)-1:0]   victim
);
   localparam int WW = way_w(WAYS);

   logic [WW-1:0] ptr [SETS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) ptr[s] <= '0;
      end else if (adv) begin
         ptr[idx] <= (ptr[idx] == WW'(WAYS-1)) ? '0 : ptr[idx] + 1'b1;
      end
   end

   always_comb begin
      victim = ptr[idx];
      for (int w = WAYS-1; w >= 0; w--)
         if (!valid[w]) victim = WW'(w);
   end
endmodule

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with word-by-word block fill.
// Optional ICACHE_STATS_EN adds saturating hit_count / miss_count outputs.
module icache_nway import cpu_types_pkg::*, icache_nway_pkg::*; #(
   parameter int SETS            = 8,
   parameter int WAYS            = 2,
   parameter int WORDS_PER_BLOCK = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic [31:0] iload,
   input  logic        iwait
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);
   localparam int OW = off_w(WORDS_PER_BLOCK);
   localparam int IW = idx_w(SETS);
   localparam int TW = tag_w(SETS, WORDS_PER_BLOCK);
   localparam int WW = way_w(WAYS);
   localparam int CW = (OW > 0) ? OW : 1;
   localparam logic [CW-1:0] LAST = CW'(WORDS_PER_BLOCK-1);

   state_t          state, nstate;
   logic [IW-1:0]   idx, idx_q, sel_idx;
   logic [TW-1:0]   tag, tag_q;
   logic [CW-1:0]   woff, cnt;
   logic [WW-1:0]   victim, vic_q, hway;
   logic [WAYS-1:0] set_valid;
   logic [31:0]     base_q;
   logic            hit_any, accept, done;

   logic [WAYS-1:0] valid_q  [SETS];
   logic [TW-1:0]   tag_mem  [SETS][WAYS];
   word_t           data_mem [SETS][WAYS][WORDS_PER_BLOCK];

   logic unused;
   assign unused = ^imemaddr[1:0];

   assign idx   = imemaddr[2+OW +: IW];
   assign tag   = imemaddr[31 -: TW];
   assign woff  = imemaddr[2 +: CW] & LAST;
   assign idx_q = base_q[2+OW +: IW];
   assign tag_q = base_q[31 -: TW];

   // Lookup set follows the request in IDLE, the latched fill set in FILL.
   assign sel_idx   = (state == FILL) ? idx_q : idx;
   assign set_valid = valid_q[sel_idx];

   always_comb begin
      hit_any = 1'b0;
      hway    = '0;
      for (int w = 0; w < WAYS; w++)
         if (valid_q[idx][w] && tag_mem[idx][w] == tag) begin
            hit_any = 1'b1;
            hway    = WW'(w);
         end
   end

   assign accept = (state == FILL) && !iwait;
   assign done   = accept && (cnt == LAST);

   cache_victim_sel #(.SETS(SETS), .WAYS(WAYS)) u_vsel (
      .clk(CLK), .rst(RST), .idx(sel_idx), .valid(set_valid), .adv(done), .victim(victim)
   );

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate   = state;
      ihit     = 1'b0;
      imemload = '0;
      iREN     = 1'b0;
      iaddr    = '0;
      case (state)
         IDLE: if (imemREN) begin
            if (hit_any) begin
               ihit     = 1'b1;
               imemload = data_mem[idx][hway][woff];
            end else begin
               nstate = FILL;
            end
         end
         FILL: begin
            iREN  = 1'b1;
            iaddr = base_q + {{(30-CW){1'b0}}, cnt, 2'b00};
            if (done) nstate = IDLE;
         end
         default: nstate = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt    <= '0;
         base_q <= '0;
         vic_q  <= '0;
         for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      end else if (state == IDLE) begin
         if (imemREN && !hit_any) begin
            base_q <= {imemaddr[31:2+OW], {(2+OW){1'b0}}};
            vic_q  <= victim;
         end
      end else if (accept) begin
         cnt <= done ? '0 : cnt + 1'b1;
         if (done) valid_q[idx_q][vic_q] <= 1'b1;
      end
   end

   // Line storage carries no reset; valid bits alone gate what is returned.
   always_ff @(posedge CLK) begin
      if (accept) data_mem[idx_q][vic_q][cnt] <= iload;
      if (done)   tag_mem[idx_q][vic_q]       <= tag_q;
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (state == IDLE && imemREN) begin
         if (hit_any) begin
            if (~&hit_count) hit_count <= hit_count + 32'd1;
         end else if (~&miss_count) begin
            miss_count <= miss_count + 32'd1;
         end
      end
   end
`endif
endmodule

// File: tb/tb_icache_nway.sv
// Scoreboard bench for icache_nway (SETS=8, WAYS=2, WORDS_PER_BLOCK=2, two wait cycles per word).
module tb_icache_nway;
   localparam int WAIT     = 2;
   localparam int MISS_LAT = 1 + 2*(WAIT+1);

   logic        CLK = 1'b0, RST = 1'b1, imemREN = 1'b0;
   logic [31:0] imemaddr = '0, iload = '0;
   logic        iwait = 1'b1;
   logic        ihit, iREN;
   logic [31:0] imemload, iaddr;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   int          n_run = 0, n_fail = 0;
   int          exp_hits = 0, exp_misses = 0;
   logic [31:0] fetch_q[$];
   logic [31:0] hit_q[$];
   logic        hold_wait = 1'b0;
   int          wcnt = 0;
   logic        prev_ren = 1'b0;
   logic [31:0] last_addr = '0;

   icache_nway dut (
      .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
      .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
      .iload(iload), .iwait(iwait)
`ifdef ICACHE_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h40) return 32'hAAAA0001;
      if (a == 32'h44) return 32'hAAAA0002;
      return 32'h5EED0000 ^ a;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Memory: each new word address is held off for WAIT cycles.
   always @(posedge CLK) begin
      #1;
      if (!iREN) begin
         iwait    = 1'b1;
         prev_ren = 1'b0;
      end else begin
         if (!prev_ren || iaddr != last_addr) wcnt = WAIT;
         prev_ren  = 1'b1;
         last_addr = iaddr;
         if (wcnt > 0 || hold_wait) begin
            iwait = 1'b1;
            if (wcnt > 0) wcnt--;
         end else begin
            iwait = 1'b0;
         end
         iload = mem_word(iaddr);
      end
   end

   always @(negedge CLK) begin
      if (!RST) begin
         if (ihit) begin
            chk("hit_req", {31'b0, imemREN}, 32'd1);
            if (hit_q.size() == 0) chk("hit_unexp", {31'b0, ihit}, 32'd0);
            else chk("hit_data", imemload, hit_q.pop_front());
         end else begin
            chk("load_idle", imemload, 32'd0);
         end
         if (iREN && !iwait) begin
            if (fetch_q.size() == 0) chk("fetch_unexp", {31'b0, iREN}, 32'd0);
            else chk("fetch_addr", iaddr, fetch_q.pop_front());
         end
      end
   end

   task automatic do_reset();
      chk("q_drain", fetch_q.size() + hit_q.size(), 32'd0);
      fetch_q.delete();
      hit_q.delete();
      RST = 1'b1; imemREN = 1'b0; imemaddr = '0;
      @(posedge CLK); #1; @(posedge CLK); #1;
      chk("rst_ihit", {31'b0, ihit}, 32'd0);
      chk("rst_iren", {31'b0, iREN}, 32'd0);
      chk("rst_iaddr", iaddr, 32'd0);
      chk("rst_load", imemload, 32'd0);
      RST = 1'b0;
      exp_hits = 0; exp_misses = 0;
   endtask

   task automatic rd(input logic [31:0] a, input bit miss);
      int lat;
      logic [31:0] blk;
      blk = a & 32'hFFFF_FFF8;
      if (miss) begin
         fetch_q.push_back(blk);
         fetch_q.push_back(blk + 32'd4);
         exp_misses++;
      end
      hit_q.push_back(mem_word(a & 32'hFFFF_FFFC));
      exp_hits++;
      imemREN = 1'b1; imemaddr = a;
      for (lat = 0; lat < 50; lat++) begin
         @(negedge CLK);
         if (ihit) break;
         @(posedge CLK); #1;
      end
      chk(miss ? "miss_lat" : "hit_lat", lat, miss ? MISS_LAT : 0);
      @(posedge CLK); #1;
      imemREN = 1'b0;
   endtask

   task automatic wait_fetch_done();
      for (int n = 0; n < 50 && fetch_q.size() != 0; n++) begin
         @(negedge CLK); #1;
      end
      chk("fill_done", fetch_q.size(), 32'd0);
      @(posedge CLK); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Cold miss then neighbour word hit.
      do_reset();
      rd(32'h40, 1);
      rd(32'h44, 0);

      // Two tags in one set, back-to-back hits.
      do_reset();
      rd(32'h40, 1);
      rd(32'h80, 1);
      rd(32'h40, 0);
      rd(32'h80, 0);
      rd(32'h44, 0);
      rd(32'h84, 0);
`ifdef ICACHE_STATS_EN
      chk("hit_count", hit_count, exp_hits);
      chk("miss_count", miss_count, exp_misses);
`endif

      // Round-robin eviction.
      do_reset();
      rd(32'h40, 1);
      rd(32'h80, 1);
      rd(32'hC0, 1);
      rd(32'h80, 0);
      rd(32'h40, 1);
      rd(32'hC0, 0);
      rd(32'h80, 1);

      // Request withdrawn mid-fill: fill still completes for 0x40.
      do_reset();
      fetch_q.push_back(32'h40);
      fetch_q.push_back(32'h44);
      imemREN = 1'b1; imemaddr = 32'h40;
      @(posedge CLK); #1;
      imemREN = 1'b0; imemaddr = 32'h100;
      wait_fetch_done();
      rd(32'h100, 1);
      rd(32'h40, 0);

      // Memory stalled indefinitely: request stays stable.
      do_reset();
      hold_wait = 1'b1;
      fetch_q.push_back(32'h80);
      fetch_q.push_back(32'h84);
      imemREN = 1'b1; imemaddr = 32'h80;
      @(posedge CLK); #1;
      imemREN = 1'b0;
      repeat (10) @(posedge CLK);
      @(negedge CLK);
      chk("stall_iren", {31'b0, iREN}, 32'd1);
      chk("stall_iaddr", iaddr, 32'h80);
      hold_wait = 1'b0;
      wait_fetch_done();
      rd(32'h84, 0);

      // Reset after the first word: partial line must not survive.
      do_reset();
      fetch_q.push_back(32'h40);
      imemREN = 1'b1; imemaddr = 32'h40;
      wait_fetch_done();
      RST = 1'b1; imemREN = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      chk("mid_rst_ihit", {31'b0, ihit}, 32'd0);
      chk("mid_rst_load", imemload, 32'd0);
      chk("mid_rst_iren", {31'b0, iREN}, 32'd0);
      chk("mid_rst_iaddr", iaddr, 32'd0);
      RST = 1'b0;
      @(posedge CLK); #1;
      rd(32'h40, 1);
      rd(32'h44, 0);

      repeat (2) @(posedge CLK);
      chk("q_final", fetch_q.size() + hit_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
